// File: rtl/jtframe_sdram_prog_if.sv
// SDRAM programming bus: one byte-masked 16-bit write request at a time,
// acknowledged by a single-cycle prog_rdy from the SDRAM controller.
interface jtframe_sdram_prog_if;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rdy;

  // Download engine side: issues writes, receives completion
  modport master (
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we,
    input  prog_rdy
  );

  // SDRAM controller side
  modport slave (
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we,
    output prog_rdy
  );
endinterface

// File: rtl/jtframe_sdram_prog.sv
// ROM download writer: queues ioctl bytes in a 4-deep FIFO, maps each byte
// address onto an SDRAM bank plus 16-bit word address, and issues one masked
// write per byte, holding the request until the controller acknowledges it.
module jtframe_sdram_prog #(
  parameter logic [26:0] BA1_START = 27'h100_0000,
  parameter logic [26:0] BA2_START = 27'h180_0000,
  parameter logic [26:0] BA3_START = 27'h200_0000,
  parameter int          SWAB      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        downloading,
  input  logic                        ioctl_rom_wr,
  input  logic [26:0]                 ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  jtframe_sdram_prog_if.master        prog,
  output logic                        dwnld_busy,
  output logic                        ovf_err,
  output logic                        rng_err
);

  localparam logic SWAB_BIT = (SWAB != 0);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, GAP} state_t;

  state_t      state, state_nx;

  // Input FIFO
  logic [34:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        fifo_full, push, pop, drop;

  // Entry currently being translated
  logic [26:0] ld_addr;
  logic [7:0]  ld_byte;

  // Bank mapping of ld_addr
  logic [1:0]  sel_ba;
  logic [26:0] sel_start;
  logic [26:0] offset;
  logic        in_range;

  // FSM strobes
  logic        load_ok, load_bad, we_out;

  // Registered write request fields
  logic [21:0] addr_r;
  logic [15:0] data_r;
  logic [1:0]  mask_r;
  logic [1:0]  ba_r;

  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign fifo_full = (count == 3'd4);
  assign push      = ioctl_rom_wr && (!fifo_full || pop);
  assign drop      = ioctl_rom_wr && fifo_full && !pop;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != 3'd0) state_nx = LOAD;
      LOAD:    state_nx = in_range ? WRITE : IDLE;
      WRITE:   if (prog.prog_rdy) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs; prog_we comes straight from the state so reset drops it at once
  always_comb begin
    pop      = 1'b0;
    load_ok  = 1'b0;
    load_bad = 1'b0;
    we_out   = 1'b0;
    case (state)
      IDLE:    pop      = (count != 3'd0);
      LOAD:    begin
                 load_ok  = in_range;
                 load_bad = !in_range;
               end
      WRITE:   we_out   = 1'b1;
      default: ;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
  end

  // Capture the head entry as it is popped in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_addr <= '0;
      ld_byte <= '0;
    end else if (pop) begin
      {ld_addr, ld_byte} <= fifo_mem[rd_ptr];
    end
  end

  // Bank selection and in-bank offset; each bank window is 8 MB
  always_comb begin
    sel_ba    = 2'd0;
    sel_start = '0;
    if (ld_addr >= BA3_START) begin
      sel_ba    = 2'd3;
      sel_start = BA3_START;
    end else if (ld_addr >= BA2_START) begin
      sel_ba    = 2'd2;
      sel_start = BA2_START;
    end else if (ld_addr >= BA1_START) begin
      sel_ba    = 2'd1;
      sel_start = BA1_START;
    end
    offset   = ld_addr - sel_start;
    in_range = (offset[26:23] == 4'd0);
  end

  // Write request fields, loaded once per byte and frozen through WRITE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= '0;
      data_r <= '0;
      mask_r <= '1;
      ba_r   <= '0;
    end else if (load_ok) begin
      ba_r   <= sel_ba;
      addr_r <= offset[22:1];
      data_r <= {ld_byte, ld_byte};
      mask_r <= (offset[0] ^ SWAB_BIT) ? 2'b01 : 2'b10;
    end
  end

  // Sticky error flags and the registered busy indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err    <= 1'b0;
      rng_err    <= 1'b0;
      dwnld_busy <= 1'b0;
    end else begin
      if (drop)     ovf_err <= 1'b1;
      if (load_bad) rng_err <= 1'b1;
      dwnld_busy <= downloading || (count != 3'd0) || (state != IDLE);
    end
  end

  assign prog.prog_addr = addr_r;
  assign prog.prog_data = data_r;
  assign prog.prog_mask = mask_r;
  assign prog.prog_ba   = ba_r;
  assign prog.prog_we   = we_out;

endmodule

// File: tb/tb_jtframe_sdram_prog.sv
// Bench for jtframe_sdram_prog: a responder plays the SDRAM controller, a
// monitor logs accepted writes, and each test compares them with writes
// predicted from the address-mapping rules.
module tb_jtframe_sdram_prog;
  localparam logic [26:0] BA1 = 27'h100_0000;
  localparam logic [26:0] BA2 = 27'h180_0000;
  localparam logic [26:0] BA3 = 27'h200_0000;
  localparam int          SWAB = 0;

  logic        clk = 1'b0, rst = 1'b0, downloading = 1'b0, ioctl_rom_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        dwnld_busy, ovf_err, rng_err;

  jtframe_sdram_prog_if bus();

  jtframe_sdram_prog #(.BA1_START(BA1), .BA2_START(BA2), .BA3_START(BA3), .SWAB(SWAB)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_rom_wr(ioctl_rom_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .prog(bus),
    .dwnld_busy(dwnld_busy), .ovf_err(ovf_err), .rng_err(rng_err)
  );

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } wr_t;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int fixed_lat = -1;
  bit rdy_en = 1'b1, rdy_force = 1'b0;
  int clr_req = 0;
  wr_t got[$];
  int  got_len[$];
  int  got_cyc[$];
  int  stab_viol = 0;
  wr_t exp_q[$];
  bit  exp_bad;
  logic [26:0] pa[$];
  logic [7:0]  pd[$];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SDRAM controller stand-in: acknowledges a write lat cycles after prog_we rises
  initial begin : responder
    int wcnt, lat;
    wcnt = 0; lat = 0; bus.prog_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.prog_we) begin
        bus.prog_rdy = rdy_force;
        wcnt = 0;
      end else begin
        if (wcnt == 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
        bus.prog_rdy = rdy_en && (wcnt >= lat);
        wcnt++;
      end
    end
  end

  // Write log: fields of every acknowledged write, request length and cycle
  initial begin : monitor
    int  we_cnt, clr_seen;
    wr_t cur, held;
    we_cnt = 0; clr_seen = 0; held = '0;
    forever begin
      @(negedge clk); #1;
      if (clr_req != clr_seen) begin
        got.delete(); got_len.delete(); got_cyc.delete();
        stab_viol = 0; we_cnt = 0; clr_seen = clr_req;
      end
      if (bus.prog_we) begin
        cur = {bus.prog_ba, bus.prog_addr, bus.prog_data, bus.prog_mask};
        if (we_cnt > 0 && cur !== held) stab_viol++;
        held = cur;
        we_cnt++;
        if (bus.prog_rdy) begin
          got.push_back(cur); got_len.push_back(we_cnt); got_cyc.push_back(cyc);
          we_cnt = 0;
        end
      end else begin
        we_cnt = 0;
      end
    end
  end

  // Reference mapping: bank by threshold, 8 MB window, word = offset/2
  function automatic wr_t model(input logic [26:0] a, input logic [7:0] d, output bit bad);
    wr_t w;
    int unsigned start, off;
    if (a >= BA3)      begin w.ba = 2'd3; start = 32'(BA3); end
    else if (a >= BA2) begin w.ba = 2'd2; start = 32'(BA2); end
    else if (a >= BA1) begin w.ba = 2'd1; start = 32'(BA1); end
    else               begin w.ba = 2'd0; start = 0; end
    off    = 32'(a) - start;
    bad    = (off >= 32'h80_0000);
    w.addr = 22'(off / 2);
    w.data = {d, d};
    w.mask = (int'(off % 2) == SWAB) ? 2'b10 : 2'b01;
    return w;
  endfunction

  function automatic logic [26:0] rand_addr();
    return 27'($urandom_range(32'h3FF_FFFF, 0));
  endfunction

  function automatic logic [26:0] rand_valid();
    logic [26:0] a;
    bit bad;
    wr_t w;
    do begin
      a = rand_addr();
      w = model(a, 8'h00, bad);
    end while (bad);
    return a;
  endfunction

  task automatic add_byte(input logic [26:0] a, input logic [7:0] d);
    wr_t w;
    bit bad;
    w = model(a, d, bad);
    if (bad) exp_bad = 1'b1;
    else     exp_q.push_back(w);
    pa.push_back(a); pd.push_back(d);
  endtask

  // Drive the staged bytes on consecutive cycles
  task automatic push_seq();
    foreach (pa[i]) begin
      @(negedge clk);
      ioctl_rom_wr = 1'b1; ioctl_addr = pa[i]; ioctl_dout = pd[i];
    end
    @(negedge clk);
    ioctl_rom_wr = 1'b0;
    pa.delete(); pd.delete();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!dwnld_busy && !downloading) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; downloading = 1'b0; ioctl_rom_wr = 1'b0;
    rdy_en = 1'b1; rdy_force = 1'b0; fixed_lat = -1;
    exp_q.delete(); exp_bad = 1'b0; clr_req++;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++; if (bus.prog_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.prog_we); end
    n_checks++; if (bus.prog_addr !== 22'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.prog_addr); end
    n_checks++; if (bus.prog_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.prog_data); end
    n_checks++; if (bus.prog_mask !== 2'b11) begin n_fail++; $display("FAIL reset_mask: got %b want 11", bus.prog_mask); end
    n_checks++; if (bus.prog_ba !== 2'b00) begin n_fail++; $display("FAIL reset_ba: got %b want 00", bus.prog_ba); end
    n_checks++; if (dwnld_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", dwnld_busy); end
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
    n_checks++; if (rng_err !== 1'b0) begin n_fail++; $display("FAIL reset_rng: got %b want 0", rng_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    fixed_lat = 2;
    pa.push_back(27'h5); pd.push_back(8'hA7);
    push_seq();
    wait_idle(60, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got busy %b want 0", dwnld_busy); end
    n_checks++; if (got.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      n_checks++; if (got[0].ba !== 2'd0) begin n_fail++; $display("FAIL single_ba: got %h want 0", got[0].ba); end
      n_checks++; if (got[0].addr !== 22'h2) begin n_fail++; $display("FAIL single_addr: got %h want 2", got[0].addr); end
      n_checks++; if (got[0].data !== 16'hA7A7) begin n_fail++; $display("FAIL single_data: got %h want a7a7", got[0].data); end
      n_checks++; if (got[0].mask !== 2'b01) begin n_fail++; $display("FAIL single_mask: got %b want 01", got[0].mask); end
      n_checks++; if (got_len[0] !== 3) begin n_fail++; $display("FAIL single_we_len: got %0d want 3", got_len[0]); end
    end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL single_stable: got %0d changes want 0", stab_viol); end
  endtask

  task automatic test_boundary();
    bit ok;
    do_reset();
    add_byte(BA1 - 27'd1, 8'h11); add_byte(BA1, 8'h22); add_byte(BA2 - 27'd1, 8'h33);
    push_seq();
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL boundary_timeout1: got busy %b want 0", dwnld_busy); end
    add_byte(BA2, 8'h44); add_byte(BA3 - 27'd1, 8'h55); add_byte(BA3, 8'h66);
    push_seq();
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL boundary_timeout2: got busy %b want 0", dwnld_busy); end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL boundary_count: got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL boundary_write%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    if (got.size() >= 1) begin
      n_checks++; if (got[0] !== {2'd1, 22'h0, 16'h2222, 2'b10}) begin n_fail++; $display("FAIL boundary_ba1_start: got %h want %h", got[0], {2'd1, 22'h0, 16'h2222, 2'b10}); end
    end
    n_checks++; if (rng_err !== exp_bad) begin n_fail++; $display("FAIL boundary_rng: got %b want %b", rng_err, exp_bad); end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL boundary_stable: got %0d want 0", stab_viol); end
  endtask

  task automatic test_range();
    bit ok;
    do_reset();
    add_byte(27'h280_0000, 8'h5A); add_byte(27'h000_1235, 8'hC3);
    push_seq();
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL range_timeout: got busy %b want 0", dwnld_busy); end
    n_checks++; if (rng_err !== 1'b1) begin n_fail++; $display("FAIL range_rng: got %b want 1", rng_err); end
    n_checks++; if (got.size() !== 1) begin n_fail++; $display("FAIL range_count: got %0d want 1", got.size()); end
    if (got.size() >= 1 && exp_q.size() >= 1) begin
      n_checks++; if (got[0] !== exp_q[0]) begin n_fail++; $display("FAIL range_write: got %h want %h", got[0], exp_q[0]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    rdy_en = 1'b0;
    for (int k = 0; k < 5; k++) add_byte(rand_valid(), 8'($urandom));
    pa.push_back(rand_valid()); pd.push_back(8'($urandom));
    push_seq();
    repeat (3) @(negedge clk); #1;
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
    n_checks++; if (bus.prog_we !== 1'b1) begin n_fail++; $display("FAIL ovf_we_held: got %b want 1", bus.prog_we); end
    n_checks++; if (got.size() !== 0) begin n_fail++; $display("FAIL ovf_early_writes: got %0d want 0", got.size()); end
    rdy_en = 1'b1;
    wait_idle(200, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_timeout: got busy %b want 0", dwnld_busy); end
    n_checks++; if (got.size() !== 5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", got.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_write%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    n_checks++; if (rng_err !== 1'b0) begin n_fail++; $display("FAIL ovf_rng: got %b want 0", rng_err); end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL ovf_stable: got %0d want 0", stab_viol); end
  endtask

  task automatic test_drain();
    int fall;
    do_reset();
    downloading = 1'b1;
    rdy_en = 1'b0;
    for (int k = 0; k < 3; k++) add_byte(rand_valid(), 8'($urandom));
    push_seq();
    repeat (2) @(negedge clk);
    downloading = 1'b0;
    repeat (2) @(negedge clk); #1;
    n_checks++; if (dwnld_busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy_held: got %b want 1", dwnld_busy); end
    fixed_lat = 0;
    rdy_en = 1'b1;
    fall = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (!dwnld_busy) begin fall = cyc; break; end
    end
    n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL drain_count: got %0d want 3", got.size()); end
    if (got.size() >= 1) begin
      n_checks++; if (fall - got_cyc[got.size() - 1] !== 3) begin n_fail++; $display("FAIL drain_busy_fall: got %0d cycles want 3", fall - got_cyc[got.size() - 1]); end
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL drain_write%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    fixed_lat = 0;
    for (int k = 0; k < 4; k++) add_byte(rand_valid(), 8'($urandom));
    push_seq();
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got busy %b want 0", dwnld_busy); end
    n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
    for (int i = 1; i < got.size(); i++) begin
      n_checks++; if (got_cyc[i] - got_cyc[i-1] !== 4) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, got_cyc[i] - got_cyc[i-1]); end
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_write%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_idle_rdy();
    bit ok;
    do_reset();
    rdy_force = 1'b1;
    fixed_lat = 2;
    repeat (3) @(negedge clk);
    add_byte(rand_valid(), 8'($urandom));
    push_seq();
    wait_idle(60, ok);
    rdy_force = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL idle_rdy_timeout: got busy %b want 0", dwnld_busy); end
    n_checks++; if (got.size() !== 1) begin n_fail++; $display("FAIL idle_rdy_count: got %0d want 1", got.size()); end
    if (got.size() >= 1 && exp_q.size() >= 1) begin
      n_checks++; if (got[0] !== exp_q[0]) begin n_fail++; $display("FAIL idle_rdy_write: got %h want %h", got[0], exp_q[0]); end
      n_checks++; if (got_len[0] !== 3) begin n_fail++; $display("FAIL idle_rdy_we_len: got %0d want 3", got_len[0]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    for (int b = 0; b < 12; b++) begin
      int n;
      n = $urandom_range(5, 1);
      downloading = 1'($urandom_range(1, 0));
      for (int k = 0; k < n; k++) add_byte(rand_addr(), 8'($urandom));
      push_seq();
      downloading = 1'b0;
      wait_idle(200, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL random_timeout%0d: got busy %b want 0", b, dwnld_busy); end
    end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_write%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    n_checks++; if (rng_err !== exp_bad) begin n_fail++; $display("FAIL random_rng: got %b want %b", rng_err, exp_bad); end
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL random_ovf: got %b want 0", ovf_err); end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL random_stable: got %0d want 0", stab_viol); end
  endtask

  task automatic test_rst_mid_write();
    bit seen;
    do_reset();
    rdy_en = 1'b0;
    for (int k = 0; k < 3; k++) add_byte(rand_valid(), 8'($urandom));
    push_seq();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bus.prog_we) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstw_we_rise: got %b want 1", seen); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.prog_we !== 1'b0) begin n_fail++; $display("FAIL rstw_we_drop: got %b want 0", bus.prog_we); end
    n_checks++; if (bus.prog_mask !== 2'b11) begin n_fail++; $display("FAIL rstw_mask: got %b want 11", bus.prog_mask); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_force = 1'b1;
    repeat (3) @(negedge clk);
    rdy_force = 1'b0;
    rdy_en = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    n_checks++; if (got.size() !== 0) begin n_fail++; $display("FAIL rstw_writes: got %0d want 0", got.size()); end
    n_checks++; if (dwnld_busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy: got %b want 0", dwnld_busy); end
    n_checks++; if (bus.prog_we !== 1'b0) begin n_fail++; $display("FAIL rstw_we_after: got %b want 0", bus.prog_we); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_range();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_idle_rdy();
    test_random();
    test_rst_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
